// File: rtl/loader_pkg.sv
// Shared definitions for the serial instruction loader: FSM states,
// the frame sync byte and the checksum helper.
`timescale 1ns/1ps
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

    localparam logic [7:0] SYNC = 8'hA5;

    // Modulo-256 running checksum step.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Serial boot loader: receives a framed byte stream (SYNC, 16-bit word
// count, little-endian 32-bit words, checksum), writes the words into
// instruction memory and releases the processor once the image checks out.
`timescale 1ns/1ps
module instr_loader
    import loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic                 reload,
    output logic [WIDTH-1:0]     instr_in,
    output logic [LOGSIZE+1:0]   instr_wr_addr,
    output logic                 instr_wr_en,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [15:0] len_r;
    logic [15:0] word_idx_r;
    logic [7:0]  csum_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] data_r;

    logic        accept_s;
    logic        reload_s;
    logic [15:0] len_full_s;
    logic        last_byte_s;
    logic        last_word_s;
    logic [31:0] word_s;

    assign accept_s    = byte_valid && byte_ready;
    assign reload_s    = reload && ((state_r == DONE) || (state_r == ERR));
    assign len_full_s  = {byte_in, len_r[7:0]};
    assign last_byte_s = (byte_cnt_r == 2'd3);
    assign last_word_s = last_byte_s && (word_idx_r == (len_r - 16'd1));
    assign word_s      = {byte_in, data_r};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode from the accepted byte and the frame counters.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (byte_in == SYNC)) state_nxt_s = LEN_LO;
                else                               state_nxt_s = IDLE;
            end
            LEN_LO: begin
                if (accept_s) state_nxt_s = LEN_HI;
                else          state_nxt_s = LEN_LO;
            end
            LEN_HI: begin
                if (!accept_s)                      state_nxt_s = LEN_HI;
                else if (len_full_s > 16'(SIZE))    state_nxt_s = ERR;
                else if (len_full_s == 16'd0)       state_nxt_s = CSUM;
                else                                state_nxt_s = DATA;
            end
            DATA: begin
                if (accept_s && last_word_s) state_nxt_s = CSUM;
                else                         state_nxt_s = DATA;
            end
            CSUM: begin
                if (!accept_s)              state_nxt_s = CSUM;
                else if (byte_in == csum_r) state_nxt_s = DONE;
                else                        state_nxt_s = ERR;
            end
            DONE, ERR: begin
                if (reload_s) state_nxt_s = IDLE;
                else          state_nxt_s = state_r;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track state_r.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            byte_ready <= (state_nxt_s != DONE) && (state_nxt_s != ERR);
            cpu_hold   <= (state_nxt_s != DONE);
            load_done  <= (state_nxt_s == DONE);
            load_err   <= (state_nxt_s == ERR);
        end
    end

    // Length capture, word assembly, checksum and the memory write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r         <= 16'd0;
            word_idx_r    <= 16'd0;
            csum_r        <= 8'd0;
            byte_cnt_r    <= 2'd0;
            data_r        <= 24'd0;
            instr_wr_en   <= 1'b0;
            instr_in      <= '0;
            instr_wr_addr <= '0;
        end else begin
            instr_wr_en <= 1'b0;
            if (reload_s) begin
                len_r      <= 16'd0;
                word_idx_r <= 16'd0;
                csum_r     <= 8'd0;
                byte_cnt_r <= 2'd0;
                data_r     <= 24'd0;
            end else if (accept_s) begin
                case (state_r)
                    LEN_LO: begin
                        len_r[7:0] <= byte_in;
                        csum_r     <= csum_add(csum_r, byte_in);
                    end
                    LEN_HI: begin
                        len_r[15:8] <= byte_in;
                        csum_r      <= csum_add(csum_r, byte_in);
                    end
                    DATA: begin
                        csum_r     <= csum_add(csum_r, byte_in);
                        data_r     <= {byte_in, data_r[23:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (last_byte_s) begin
                            instr_wr_en   <= 1'b1;
                            instr_in      <= WIDTH'(word_s);
                            instr_wr_addr <= {word_idx_r[LOGSIZE-1:0], 2'b00};
                            word_idx_r    <= word_idx_r + 16'd1;
                        end else begin
                            instr_wr_en <= 1'b0;
                        end
                    end
                    default: begin
                        instr_wr_en <= 1'b0;
                    end
                endcase
            end else begin
                instr_wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected memory writes are queued as
// each frame is sent and popped by a monitor whenever the write strobe fires.
`timescale 1ns/1ps
module tb_instr_loader;

    localparam int WIDTH = 32;
    localparam int SIZE  = 64;
    localparam int AW    = $clog2(SIZE) + 2;

    logic             clk;
    logic             reset;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             reload;
    logic [WIDTH-1:0] instr_in;
    logic [AW-1:0]    instr_wr_addr;
    logic             instr_wr_en;
    logic             cpu_hold;
    logic             load_done;
    logic             load_err;

    instr_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk           (clk),
        .reset         (reset),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .reload        (reload),
        .instr_in      (instr_in),
        .instr_wr_addr (instr_wr_addr),
        .instr_wr_en   (instr_wr_en),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    wr_t         sb_q[$];
    logic [31:0] img_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (instr_wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_wr", {{(32-AW){1'b0}}, instr_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check_val("wr_addr", {{(32-AW){1'b0}}, instr_wr_addr}, {{(32-AW){1'b0}}, e.addr});
                check_val("wr_data", instr_in, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 8 && !byte_ready; i++) @(negedge clk);
        if (!byte_ready) check_val("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] csum_bias);
        logic [15:0] n;
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        n  = 16'(img_q.size());
        cs = n[7:0] + n[15:8];
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < img_q.size(); i++) begin
            w      = img_q[i];
            e.addr = AW'(i * 4);
            e.data = w;
            sb_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                cs = cs + w[k*8 +: 8];
                send_byte(w[k*8 +: 8]);
            end
        end
        send_byte(cs + csum_bias);
    endtask

    task automatic wait_cycles(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    task automatic reload_pulse();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic expect_status(input string tag, input logic done, input logic err);
        check_val({tag, "_done"},  {31'd0, load_done},  {31'd0, done});
        check_val({tag, "_err"},   {31'd0, load_err},   {31'd0, err});
        check_val({tag, "_hold"},  {31'd0, cpu_hold},   {31'd0, ~done});
        check_val({tag, "_ready"}, {31'd0, byte_ready}, {31'd0, ~(done | err)});
    endtask

    task automatic check_reset_state(input string tag);
        expect_status(tag, 1'b0, 1'b0);
        check_val({tag, "_wr_en"}, {31'd0, instr_wr_en}, 32'd0);
        check_val({tag, "_instr"}, instr_in, 32'd0);
        check_val({tag, "_addr"},  {{(32-AW){1'b0}}, instr_wr_addr}, 32'd0);
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        reload     = 1'b0;
        wait_cycles(3);
        check_reset_state("rst");
        reset = 1'b1;

        // Single word image with hand-computed checksum 01+00+13 = 14.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        sb_q.push_back('{addr: AW'(0), data: 32'h0000_0013});
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h14);
        wait_cycles(2);
        expect_status("one_word", 1'b1, 1'b0);

        // Two words at addresses 0 and 4.
        reload_pulse();
        expect_status("after_reload", 1'b0, 1'b0);
        img_q = '{32'h1122_3344, 32'h5566_7788};
        send_image(8'd0);
        wait_cycles(2);
        expect_status("two_words", 1'b1, 1'b0);

        // Word count one above memory depth: error straight after LEN_HI.
        reload_pulse();
        send_byte(8'hA5);
        send_byte(8'h41);
        send_byte(8'h00);
        wait_cycles(2);
        expect_status("len_over", 1'b0, 1'b1);

        // Bad checksum: writes still happen, then error; reload recovers.
        reload_pulse();
        img_q = '{$urandom, $urandom, $urandom};
        send_image(8'd1);
        wait_cycles(2);
        expect_status("bad_csum", 1'b0, 1'b1);
        reload_pulse();
        img_q = '{$urandom, $urandom};
        send_image(8'd0);
        wait_cycles(2);
        expect_status("recover", 1'b1, 1'b0);

        // Reset mid-word: partial data discarded, next image starts at 0.
        reload_pulse();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);
        check_reset_state("mid_rst");
        reset = 1'b1;
        img_q = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
        send_image(8'd0);
        wait_cycles(2);
        expect_status("post_rst", 1'b1, 1'b0);

        // Garbage before SYNC, a non-valid SYNC value, and an ignored reload.
        reload_pulse();
        send_byte(8'h00);
        @(negedge clk);
        byte_in = 8'hA5;
        wait_cycles(2);
        send_byte(8'hFF);
        reload_pulse();
        img_q = '{32'hCAFE_0001};
        send_image(8'd0);
        wait_cycles(2);
        expect_status("garbage", 1'b1, 1'b0);

        // Empty image: straight to checksum.
        reload_pulse();
        img_q.delete();
        send_image(8'd0);
        wait_cycles(2);
        expect_status("n_zero", 1'b1, 1'b0);

        // Full memory depth.
        reload_pulse();
        img_q.delete();
        for (int i = 0; i < SIZE; i++) img_q.push_back($urandom);
        send_image(8'd0);
        wait_cycles(2);
        expect_status("n_full", 1'b1, 1'b0);

        wait_cycles(2);
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
